nnrv_wb_arb: RTL and testbench
==============================

Name: nnrv_wb_arb

Overview:
- Arbitrates the single register-file write port between two sources: the in-order pipeline writeback and a long-latency unit such as MUL/DIV.
- Pipeline writes have priority. The long-latency unit uses a valid/ready handshake.
- A starvation counter forces a pipeline bubble so long-latency results always drain.
- A 32-entry busy scoreboard tracks outstanding long-latency destinations for the hazard logic.

Parameters:
- XLEN, 32, data width of register values.
- STARVE_MAX, 4, number of consecutive refused long-latency cycles before the pipeline is stalled (legal range 1..15).

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; synchronous, active-low.
- i_pipe_w_en  input  1  pipeline writeback request.
- i_pipe_w  input  5  pipeline destination register.
- i_pipe_w_reg  input  XLEN  pipeline write data.
- i_ll_issue  input  1  long-latency op issued this cycle.
- i_ll_issue_rd  input  5  destination of the issued long-latency op.
- i_ll_valid  input  1  long-latency result available.
- i_ll_rd  input  5  long-latency result destination.
- i_ll_data  input  XLEN  long-latency result data.
- o_ll_ready  output  1  long-latency result accepted this cycle.
- o_stall_pipe  output  1  pipeline must insert a writeback bubble.
- o_busy  output  32  scoreboard; bit n set means reg n has a long-latency write pending.
- o_reg_w_en  output  1  register-file write enable.
- o_reg_w  output  5  register-file write address.
- o_reg_w_reg  output  XLEN  register-file write data.

Behaviour:
- Reset (i_rst==0 at a rising edge):
  - o_reg_w_en, o_reg_w, o_reg_w_reg, o_busy, o_stall_pipe and the starvation counter all go to 0.
  - o_ll_ready is 0 while i_rst==0.
  - Reset mid-operation discards any pending long-latency request state and clears the scoreboard. The long-latency unit is reset by the same signal.
- Arbitration (combinational):
  - o_ll_ready = i_rst & ~i_pipe_w_en.
  - A long-latency handshake occurs when i_ll_valid & o_ll_ready.
  - The pipeline always wins a same-cycle conflict. The pipeline is never back-pressured in that cycle.
- Write port (registered, 1-cycle latency):
  - Next cycle after a pipeline request: the port carries i_pipe_w / i_pipe_w_reg.
  - Next cycle after a long-latency handshake: the port carries i_ll_rd / i_ll_data.
  - With neither: o_reg_w_en=0, and address/data hold their previous values.
  - x0 suppression: o_reg_w_en is forced to 0 when the selected address is 0. The handshake still completes.
- Starvation control:
  - Counter (4 bits) increments each cycle i_ll_valid & ~o_ll_ready, saturating at STARVE_MAX.
  - It clears on a handshake or when i_ll_valid==0.
  - o_stall_pipe is registered. It is set on the edge where the counter reaches STARVE_MAX and cleared on the edge of the handshake cycle.
  - Pipeline contract: while o_stall_pipe==1, i_pipe_w_en==0. The bubble therefore guarantees a handshake in the first stalled cycle.
  - If the contract is violated, the pipeline still wins and the stall remains asserted.
- Scoreboard (registered):
  - i_ll_issue with i_ll_issue_rd!=0 sets o_busy[i_ll_issue_rd].
  - A handshake clears o_busy[i_ll_rd].
  - Same register set and cleared in the same cycle: set wins (a new op has been issued).
  - Bit 0 is always 0.
  - Pipeline writes do not touch the scoreboard. WAW avoidance is the responsibility of the hazard logic.
- States (implicit): IDLE (counter=0), WAIT (0<counter<STARVE_MAX), STALL (o_stall_pipe=1).
  - IDLE→WAIT on a refused request.
  - WAIT→STALL on the counter reaching STARVE_MAX.
  - Any state→IDLE on a handshake or on i_ll_valid dropping.

Test Plan:
- Reset: hold i_rst=0 for 2 cycles with random inputs → all outputs 0, o_ll_ready=0; release → o_ll_ready=1 with no pipe request.
- Pipe-only: i_pipe_w_en=1, i_pipe_w=5, data 0x1234 → next cycle o_reg_w_en=1, o_reg_w=5, o_reg_w_reg=0x1234. Repeat with i_pipe_w=0 → o_reg_w_en=0.
- Conflict: pipe (rd 3, 0xAA) and ll (rd 7, 0xBB) valid in cycle N; pipe idle in N+1 → port shows rd 3 at N+1 and rd 7 at N+2; o_ll_ready=0 at N and 1 at N+1.
- Starvation, STARVE_MAX=4: continuous pipe writes with ll valid → o_stall_pipe rises after 4 refused cycles; the bench drops i_pipe_w_en → handshake occurs, and o_stall_pipe=0 the following cycle.
- Scoreboard: issue rd 9 → o_busy[9]=1 next cycle. Complete rd 9 while issuing rd 9 in the same cycle → o_busy[9] stays 1. Complete alone → o_busy[9]=0. Issue rd 0 → o_busy unchanged.
- Reset mid-stall: assert i_rst=0 while o_stall_pipe=1 and o_busy≠0 → both clear next edge, and the counter restarts from 0.

Source files
------------

// File: rtl/nnrv_wb_arb.sv
// nnrv_wb_arb: register-file write port arbiter between pipeline writeback and a long-latency unit
module nnrv_wb_arb #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_pipe_w_en,
    input  logic [4:0]      i_pipe_w,
    input  logic [XLEN-1:0] i_pipe_w_reg,
    input  logic            i_ll_issue,
    input  logic [4:0]      i_ll_issue_rd,
    input  logic            i_ll_valid,
    input  logic [4:0]      i_ll_rd,
    input  logic [XLEN-1:0] i_ll_data,
    output logic            o_ll_ready,
    output logic            o_stall_pipe,
    output logic [31:0]     o_busy,
    output logic            o_reg_w_en,
    output logic [4:0]      o_reg_w,
    output logic [XLEN-1:0] o_reg_w_reg
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic            hs;
    logic            sel;
    logic            idle_n;
    logic [3:0]      cnt;
    logic [3:0]      cnt_n;
    logic            stall_n;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
    logic [31:0]     busy_n;
    always_comb begin
        o_ll_ready = i_rst & ~i_pipe_w_en;
        hs         = i_ll_valid & o_ll_ready;
        sel        = i_pipe_w_en | hs;
        addr       = i_pipe_w_en ? i_pipe_w : i_ll_rd;
        data       = i_pipe_w_en ? i_pipe_w_reg : i_ll_data;
        idle_n     = hs | ~i_ll_valid;
        cnt_n      = idle_n ? 4'd0 : (cnt == SMAX ? cnt : cnt + 4'd1);
        stall_n    = idle_n ? 1'b0 : (cnt_n == SMAX) | o_stall_pipe;
        busy_n     = (o_busy & ~(hs ? 32'(1) << i_ll_rd : 32'd0))
                   | (i_ll_issue ? 32'(1) << i_ll_issue_rd : 32'd0);
        busy_n[0]  = 1'b0;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt          <= '0;
            o_stall_pipe <= 1'b0;
            o_busy       <= '0;
            o_reg_w_en   <= 1'b0;
            o_reg_w      <= '0;
            o_reg_w_reg  <= '0;
        end else begin
            cnt          <= cnt_n;
            o_stall_pipe <= stall_n;
            o_busy       <= busy_n;
            o_reg_w_en   <= sel && addr != 5'd0;
            if (sel) begin
                o_reg_w     <= addr;
                o_reg_w_reg <= data;
            end
        end
    end
endmodule

// File: tb/tb_nnrv_wb_arb.sv
// tb_nnrv_wb_arb: directed vector bench for nnrv_wb_arb
module tb_nnrv_wb_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_w_en;
    logic [4:0]  pipe_w;
    logic [31:0] pipe_w_reg;
    logic        ll_issue;
    logic [4:0]  ll_issue_rd;
    logic        ll_valid;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        ll_ready;
    logic        stall_pipe;
    logic [31:0] busy;
    logic        reg_w_en;
    logic [4:0]  reg_w;
    logic [31:0] reg_w_reg;

    nnrv_wb_arb #(.XLEN(32), .STARVE_MAX(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_pipe_w_en  (pipe_w_en),
        .i_pipe_w     (pipe_w),
        .i_pipe_w_reg (pipe_w_reg),
        .i_ll_issue   (ll_issue),
        .i_ll_issue_rd(ll_issue_rd),
        .i_ll_valid   (ll_valid),
        .i_ll_rd      (ll_rd),
        .i_ll_data    (ll_data),
        .o_ll_ready   (ll_ready),
        .o_stall_pipe (stall_pipe),
        .o_busy       (busy),
        .o_reg_w_en   (reg_w_en),
        .o_reg_w      (reg_w),
        .o_reg_w_reg  (reg_w_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pen;
        logic [4:0]  pw;
        logic [31:0] pd;
        logic        iss;
        logic [4:0]  ird;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        rdy;
        logic        wen;
        logic [4:0]  w;
        logic [31:0] wd;
        logic [31:0] busy;
        logic        stall;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // inputs change at negedge; ready is combinational, the rest is checked after the next posedge
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst; pipe_w_en = v.pen; pipe_w = v.pw; pipe_w_reg = v.pd;
        ll_issue = v.iss; ll_issue_rd = v.ird; ll_valid = v.lv; ll_rd = v.lrd; ll_data = v.ld;
        #1 chk("ll_ready", idx, 32'(ll_ready), 32'(v.rdy));
        @(posedge clk);
        #1;
        chk("reg_w_en", idx, 32'(reg_w_en), 32'(v.wen));
        chk("reg_w", idx, 32'(reg_w), 32'(v.w));
        chk("reg_w_reg", idx, reg_w_reg, v.wd);
        chk("busy", idx, busy, v.busy);
        chk("stall_pipe", idx, 32'(stall_pipe), 32'(v.stall));
    endtask

    vec_t tbl[12];
    vec_t v;

    initial begin
        tbl[0]  = '{1, 1, 5, 'h1234, 0, 0, 0, 0, 0,     0, 1, 5, 'h1234, 0, 0};
        tbl[1]  = '{1, 1, 0, 'h5678, 0, 0, 0, 0, 0,     0, 0, 0, 'h5678, 0, 0};
        tbl[2]  = '{1, 0, 0, 0,      0, 0, 0, 0, 0,     1, 0, 0, 'h5678, 0, 0};
        tbl[3]  = '{1, 1, 3, 'hAA,   0, 0, 1, 7, 'hBB,  0, 1, 3, 'hAA,   0, 0};
        tbl[4]  = '{1, 0, 0, 0,      0, 0, 1, 7, 'hBB,  1, 1, 7, 'hBB,   0, 0};
        tbl[5]  = '{1, 0, 0, 0,      0, 0, 0, 0, 0,     1, 0, 7, 'hBB,   0, 0};
        tbl[6]  = '{1, 0, 0, 0,      1, 9, 0, 0, 0,     1, 0, 7, 'hBB,   'h200, 0};
        tbl[7]  = '{1, 0, 0, 0,      1, 9, 1, 9, 'h99,  1, 1, 9, 'h99,   'h200, 0};
        tbl[8]  = '{1, 0, 0, 0,      0, 0, 1, 9, 'h9A,  1, 1, 9, 'h9A,   0, 0};
        tbl[9]  = '{1, 0, 0, 0,      1, 0, 0, 0, 0,     1, 0, 9, 'h9A,   0, 0};
        tbl[10] = '{1, 0, 0, 0,      1, 12, 1, 0, 'h77, 1, 0, 0, 'h77,   'h1000, 0};
        tbl[11] = '{1, 0, 0, 0,      1, 0, 0, 0, 0,     1, 0, 0, 'h77,   'h1000, 0};

        rst = 0; pipe_w_en = 0; pipe_w = 0; pipe_w_reg = 0;
        ll_issue = 0; ll_issue_rd = 0; ll_valid = 0; ll_rd = 0; ll_data = 0;

        for (int i = 0; i < 2; i++) begin
            v = '{0, 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom),
                  1'($urandom), 5'($urandom), $urandom, 0, 0, 0, 0, 0, 0};
            apply(v, 100 + i);
        end
        apply('{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0}, 102);

        for (int i = 0; i < 12; i++) apply(tbl[i], i);

        for (int k = 1; k <= 5; k++) begin
            v = '{1, 1, 5'(k), 32'(k * 16), 0, 0, 1, 20, 'hDEAD,
                  0, 1, 5'(k), 32'(k * 16), 'h1000, k >= 4};
            apply(v, 200 + k);
        end
        apply('{1, 0, 0, 0, 0, 0, 1, 20, 'hDEAD, 1, 1, 20, 'hDEAD, 'h1000, 0}, 206);

        for (int k = 1; k <= 4; k++) begin
            v = '{1, 1, 5'(k), 32'(k * 16), k == 1, 5, 1, 20, 'hDEAD,
                  0, 1, 5'(k), 32'(k * 16), 'h1020, k == 4};
            apply(v, 300 + k);
        end
        apply('{0, 1, 3, 'h33, 1, 6, 1, 20, 'hDEAD, 0, 0, 0, 0, 0, 0}, 305);
        for (int k = 1; k <= 4; k++) begin
            v = '{1, 1, 5'(k + 8), 32'(k), 0, 0, 1, 20, 'hBEEF,
                  0, 1, 5'(k + 8), 32'(k), 0, k == 4};
            apply(v, 310 + k);
        end
        apply('{1, 0, 0, 0, 0, 0, 1, 20, 'hBEEF, 1, 1, 20, 'hBEEF, 0, 0}, 315);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
